sdram_init_sched: RTL
=====================

SDRAM_INIT_SCHED -- requirements
Module: sdram_init_sched

Interface
REQ-001 SHALL have parameter T_PWR, default 10000, meaning power-up wait in clk cycles (legal range 1..65535).
REQ-002 SHALL have parameter T_RP, default 2, meaning precharge-to-next-command cycles (legal range 1..15).
REQ-003 SHALL have parameter T_RFC, default 7, meaning refresh-to-next-command cycles (legal range 1..15).
REQ-004 SHALL have parameter T_MRD, default 2, meaning mode-load-to-next-command cycles (legal range 1..15).
REQ-005 SHALL have parameter REF_INT, default 780, meaning cycles between refresh requests (legal range 16..65535).
REQ-006 SHALL have parameter MODE_VAL, default 13'h0033, meaning mode register value.
REQ-007 SHALL have port clk, input, 1 bit, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port pwr_reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port req, input, 2 bits, per-requester access request (level).
REQ-010 SHALL have port gnt, output, 2 bits, one-hot grant (level), zero when nobody owns the SDRAM.
REQ-011 SHALL have port cmd, output, 4 bits, {cs_n,ras_n,cas_n,we_n} issued by this block.
REQ-012 SHALL have port addr, output, 13 bits, SDRAM address bus while this block drives commands.
REQ-013 SHALL have port init_done, output, 1 bit, high once the init sequence completes.
REQ-014 SHALL have port ref_busy, output, 1 bit, high in any refresh state (init or periodic).

Function
REQ-015 SHALL encode commands: NOP 4'b0111, PRECHARGE 4'b0010, REFRESH 4'b0001, LOAD_MODE 4'b0000.
REQ-016 SHALL drive cmd=NOP and addr=0 in every cycle not listed as a command cycle.
REQ-017 SHALL sequence init states: WAIT_PWR (T_PWR cycles) -> PRE (1 cycle, PRECHARGE, addr[10]=1) -> WAIT_RP (T_RP) -> REF1 (REFRESH) -> WAIT_RFC1 (T_RFC) -> REF2 (REFRESH) -> WAIT_RFC2 (T_RFC) -> LMR (LOAD_MODE, addr=MODE_VAL) -> WAIT_MRD (T_MRD) -> IDLE.
REQ-018 SHALL assert init_done from the cycle IDLE is first entered and hold it until reset.
REQ-019 SHALL ignore req and keep gnt=0 until init_done.
REQ-020 SHALL run a refresh interval counter from IDLE entry, reloading to REF_INT-1 and setting ref_pend when it reaches 0; ref_pend is a single flag (further expiries while pending are not counted).
REQ-021 SHALL, in IDLE with ref_pend=1, go to AREF (1 cycle, REFRESH, clears ref_pend) -> WAIT_RFC (T_RFC) -> IDLE, regardless of req.
REQ-022 SHALL, in IDLE with ref_pend=0 and req!=0, go to GRANT and assert gnt one cycle after the state change decision (registered).
REQ-023 SHALL arbitrate round-robin: on simultaneous requests grant the requester not granted last; first arbitration after reset favours req[0].
REQ-024 SHALL hold gnt while the owner keeps req high, even if ref_pend sets; refresh waits for release.
REQ-025 SHALL, when the owner drops req, deassert gnt in the next cycle and return to IDLE; the other requester or a pending refresh is served from IDLE (at least one IDLE cycle between owners).
REQ-026 SHALL drive cmd=NOP during GRANT (owner drives SDRAM through an external mux selected by gnt).
REQ-027 SHALL never assert gnt and ref_busy in the same cycle; gnt SHALL be one-hot or zero.
REQ-028 SHALL implement wait counters with width sufficient for 16-bit parameters, without wrap-around.

Reset
REQ-029 SHALL on pwr_reset_n low immediately force state=WAIT_PWR, gnt=0, cmd=NOP, addr=0, init_done=0, ref_busy=0, ref_pend=0, round-robin pointer to favour req[0], all counters cleared.
REQ-030 SHALL restart the full init sequence after reset deasserts, including when reset hits mid-GRANT or mid-refresh.

Verification
REQ-031 Bench SHALL check init with T_PWR=20: PRECHARGE with addr[10]=1 at cycle 20 after reset release, REFRESH at 20+1+T_RP and a second T_RFC+1 cycles later, LOAD_MODE addr=13'h0033, init_done high T_MRD+1 cycles after LOAD_MODE.
REQ-032 Bench SHALL check req=2'b11 held from init_done: gnt=2'b01 first; on req[0] drop gnt=00 then 2'b10 after one IDLE cycle.
REQ-033 Bench SHALL check REF_INT=16, no requests: REFRESH every 16 cycles during idle, ref_busy high for 1+T_RFC cycles each time.
REQ-034 Bench SHALL check refresh expiry during a 40-cycle grant: gnt stays, exactly one REFRESH follows release before any new grant.
REQ-035 Bench SHALL check pwr_reset_n pulsed low mid-GRANT: gnt and init_done drop asynchronously, and after release init repeats with req ignored until init_done.

Source files
------------

// File: rtl/sdram_init_sched.sv
`timescale 1ns/1ps
// sdram_init_sched: SDRAM power-up initialisation sequencer, periodic
// auto-refresh scheduler and two-requester round-robin ownership arbiter.
// All outputs decode from registered state, so they change only on clk
// or on the asynchronous reset.
module sdram_init_sched #(
  parameter int unsigned T_PWR    = 10000,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RFC    = 7,
  parameter int unsigned T_MRD    = 2,
  parameter int unsigned REF_INT  = 780,
  parameter logic [12:0] MODE_VAL = 13'h0033
) (
  input  logic        clk,
  input  logic        pwr_reset_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic [3:0]  cmd,
  output logic [12:0] addr,
  output logic        init_done,
  output logic        ref_busy,
  output logic [3:0]  dbg_state
);

  // Ownership handshake: a requester raises req and holds it for as long as it
  // wants the SDRAM; gnt rises the cycle after arbitration, stays up while the
  // owner's req stays up, and falls the cycle after that req falls.

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  // Terminal counts: a wait of N cycles ends when the counter shows N-1.
  localparam logic [15:0] PWR_LAST   = 16'(T_PWR - 1);
  localparam logic [15:0] RP_LAST    = 16'(T_RP - 1);
  localparam logic [15:0] RFC_LAST   = 16'(T_RFC - 1);
  localparam logic [15:0] MRD_LAST   = 16'(T_MRD - 1);
  localparam logic [15:0] REF_RELOAD = 16'(REF_INT - 1);

  typedef enum logic [3:0] {
    S_WAIT_PWR  = 4'd0,
    S_PRE       = 4'd1,
    S_WAIT_RP   = 4'd2,
    S_REF1      = 4'd3,
    S_WAIT_RFC1 = 4'd4,
    S_REF2      = 4'd5,
    S_WAIT_RFC2 = 4'd6,
    S_LMR       = 4'd7,
    S_WAIT_MRD  = 4'd8,
    S_IDLE      = 4'd9,
    S_AREF      = 4'd10,
    S_WAIT_RFC  = 4'd11,
    S_GRANT     = 4'd12
  } state_t;

  state_t      state, state_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_last;
  logic [15:0] ref_cnt;
  logic        is_wait;
  logic        wait_done;
  logic        ref_pend;
  logic        last_gnt;
  logic        pick;

  assign dbg_state = state;
  assign wait_done = is_wait && (wait_cnt == wait_last);
  // Both requesting: take the one not served last; otherwise the lone requester.
  assign pick      = (req == 2'b11) ? ~last_gnt : req[1];

  // Select the terminal count for whichever timed wait state is active.
  always_comb begin
    is_wait   = 1'b1;
    wait_last = 16'd0;
    case (state)
      S_WAIT_PWR:                          wait_last = PWR_LAST;
      S_WAIT_RP:                           wait_last = RP_LAST;
      S_WAIT_RFC1, S_WAIT_RFC2, S_WAIT_RFC: wait_last = RFC_LAST;
      S_WAIT_MRD:                          wait_last = MRD_LAST;
      default:                             is_wait   = 1'b0;
    endcase
  end

  // Next-state decision and per-state command/status decode.
  always_comb begin
    state_next = state;
    gnt        = 2'b00;
    cmd        = CMD_NOP;
    addr       = 13'h0000;
    init_done  = 1'b0;
    ref_busy   = 1'b0;
    case (state)
      S_WAIT_PWR:  if (wait_done) state_next = S_PRE;
      S_PRE: begin
        cmd        = CMD_PRE;
        addr       = 13'h0400;  // A10 high: precharge all banks
        state_next = S_WAIT_RP;
      end
      S_WAIT_RP:   if (wait_done) state_next = S_REF1;
      S_REF1: begin
        cmd        = CMD_REF;
        ref_busy   = 1'b1;
        state_next = S_WAIT_RFC1;
      end
      S_WAIT_RFC1: begin
        ref_busy = 1'b1;
        if (wait_done) state_next = S_REF2;
      end
      S_REF2: begin
        cmd        = CMD_REF;
        ref_busy   = 1'b1;
        state_next = S_WAIT_RFC2;
      end
      S_WAIT_RFC2: begin
        ref_busy = 1'b1;
        if (wait_done) state_next = S_LMR;
      end
      S_LMR: begin
        cmd        = CMD_LMR;
        addr       = MODE_VAL;
        state_next = S_WAIT_MRD;
      end
      S_WAIT_MRD:  if (wait_done) state_next = S_IDLE;
      S_IDLE: begin
        init_done = 1'b1;
        // A pending refresh always beats a requester.
        if (ref_pend)            state_next = S_AREF;
        else if (req != 2'b00)   state_next = S_GRANT;
      end
      S_AREF: begin
        init_done  = 1'b1;
        ref_busy   = 1'b1;
        cmd        = CMD_REF;
        state_next = S_WAIT_RFC;
      end
      S_WAIT_RFC: begin
        init_done = 1'b1;
        ref_busy  = 1'b1;
        if (wait_done) state_next = S_IDLE;
      end
      S_GRANT: begin
        init_done = 1'b1;
        gnt       = last_gnt ? 2'b10 : 2'b01;
        // The owner keeps the SDRAM until it lets go; refresh waits.
        if (!req[last_gnt]) state_next = S_IDLE;
      end
      default:     state_next = S_WAIT_PWR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge pwr_reset_n) begin
    if (!pwr_reset_n) state <= S_WAIT_PWR;
    else              state <= state_next;
  end

  // Wait counter: restarts on every state change, advances only in wait states.
  always_ff @(posedge clk or negedge pwr_reset_n) begin
    if (!pwr_reset_n)             wait_cnt <= 16'd0;
    else if (state_next != state) wait_cnt <= 16'd0;
    else if (is_wait)             wait_cnt <= wait_cnt + 16'd1;
  end

  // Refresh interval timer, started on IDLE entry, feeding a single pending flag.
  always_ff @(posedge clk or negedge pwr_reset_n) begin
    if (!pwr_reset_n) begin
      ref_cnt  <= 16'd0;
      ref_pend <= 1'b0;
    end else begin
      if (state == S_WAIT_MRD && wait_done) ref_cnt <= REF_RELOAD;
      else if (init_done) begin
        if (ref_cnt == 16'd0) ref_cnt <= REF_RELOAD;
        else                  ref_cnt <= ref_cnt - 16'd1;
      end
      // A fresh expiry wins over the clear issued by the refresh command.
      if (init_done && ref_cnt == 16'd0) ref_pend <= 1'b1;
      else if (state == S_AREF)          ref_pend <= 1'b0;
    end
  end

  // Round-robin pointer: remembers the most recent owner (reset favours req[0]).
  always_ff @(posedge clk or negedge pwr_reset_n) begin
    if (!pwr_reset_n)                                   last_gnt <= 1'b1;
    else if (state == S_IDLE && state_next == S_GRANT)  last_gnt <= pick;
  end

endmodule
